// File: rtl/rx_frame_parser_pkg.sv
// Shared encodings and constants for the receive frame parser.
// Pure declarations; no latency or flow control of its own.
package rx_frame_parser_pkg;

    localparam int pFSM_BUS_WIDHT = 3;

    typedef enum logic [pFSM_BUS_WIDHT-1:0] {
        lpIDLE     = 3'd0,
        lpPREAMBLE = 3'd1,
        lpSFD      = 3'd2,
        lpDA       = 3'd3,
        lpSA       = 3'd4,
        lpTYPE     = 3'd5,
        lpPAYLOAD  = 3'd6,
        lpDROP     = 3'd7
    } frame_state_e;

    localparam logic [7:0]  lpPREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  lpSFD_BYTE      = 8'hD5;
    localparam logic [31:0] lpCRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] lpCRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] lpCRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [10:0] lpLEN_SAT       = 11'h7FF;

    // States in which a byte is forwarded to the packet memory.
    function automatic logic in_frame(input frame_state_e s);
        return s inside {lpSFD, lpDA, lpSA, lpTYPE, lpPAYLOAD};
    endfunction

    // States whose bytes are covered by CRC and length.
    function automatic logic in_body(input frame_state_e s);
        return s inside {lpDA, lpSA, lpTYPE, lpPAYLOAD};
    endfunction

endpackage

// File: rtl/rx_frame_parser_crc32.sv
// Reflected CRC-32 advanced by one byte; purely combinational, zero latency.
// No flow control: the caller decides when the result is loaded.
module crc32_d8
    import rx_frame_parser_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ lpCRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rx_frame_parser.sv
// Parses PHY receive bytes into frame fields, checks FCS and length; 1-cycle output latency.
// No backpressure: the PHY stream cannot be stalled, verdict strobes appear one cycle after the last byte.
module rx_frame_parser
    import rx_frame_parser_pkg::*;
#(
    parameter int pDATA_WIDTH        = 8,
    parameter int pMIN_PACKET_LENGHT = 64,
    parameter int pMAX_PACKET_LENGHT = 1518,
    parameter int pCNT_WIDTH         = 16
) (
    input  logic                      iclk,
    input  logic                      irst,
    input  logic                      idv,
    input  logic [pDATA_WIDTH-1:0]    irx_d,
    input  logic                      irx_er,
    output logic                      odv,
    output logic [pDATA_WIDTH-1:0]    orx_d,
    output logic                      orx_er,
    output logic [pFSM_BUS_WIDHT-1:0] oframe_state,
    output logic                      ook,
    output logic [pCNT_WIDTH-1:0]     ogood_cnt,
    output logic [pCNT_WIDTH-1:0]     obad_cnt
);

    localparam logic [10:0] MIN_LEN = 11'(pMIN_PACKET_LENGHT);
    localparam logic [10:0] MAX_LEN = 11'(pMAX_PACKET_LENGHT);

    frame_state_e            state_q, state_d, dec_st;
    frame_state_e            fst_q;
    logic [2:0]              fcnt_q, fcnt_d;
    logic [31:0]             crc_q, crc_d, crc_next;
    logic [10:0]             len_q, len_d;
    logic                    odv_q, odv_d;
    logic [pDATA_WIDTH-1:0]  rxd_q;
    logic                    er_q, er_d;
    logic                    ok_q, ok_d;
    logic [pCNT_WIDTH-1:0]   good_cnt_q, good_cnt_d;
    logic [pCNT_WIDTH-1:0]   bad_cnt_q, bad_cnt_d;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .d       (irx_d[7:0]),
        .crc_out (crc_next)
    );

    always_comb begin
        dec_st  = lpIDLE;
        state_d = lpIDLE;
        fcnt_d  = fcnt_q;
        crc_d   = crc_q;
        len_d   = len_q;
        ok_d    = 1'b0;
        er_d    = 1'b0;

        if (idv) begin
            // fcnt_q counts bytes already consumed in the current address/type field.
            case (state_q)
                lpIDLE:     dec_st = (irx_d[7:0] == lpPREAMBLE_BYTE) ? lpPREAMBLE : lpDROP;
                lpPREAMBLE: begin
                    if (irx_d[7:0] == lpPREAMBLE_BYTE) dec_st = lpPREAMBLE;
                    else if (irx_d[7:0] == lpSFD_BYTE) dec_st = lpSFD;
                    else                               dec_st = lpDROP;
                end
                lpSFD: begin
                    dec_st = lpDA;
                    fcnt_d = 3'd1;
                end
                lpDA: begin
                    dec_st = (fcnt_q == 3'd6) ? lpSA : lpDA;
                    fcnt_d = (fcnt_q == 3'd6) ? 3'd1 : fcnt_q + 3'd1;
                end
                lpSA: begin
                    dec_st = (fcnt_q == 3'd6) ? lpTYPE : lpSA;
                    fcnt_d = (fcnt_q == 3'd6) ? 3'd1 : fcnt_q + 3'd1;
                end
                lpTYPE: begin
                    dec_st = (fcnt_q == 3'd2) ? lpPAYLOAD : lpTYPE;
                    fcnt_d = fcnt_q + 3'd1;
                end
                lpPAYLOAD:  dec_st = lpPAYLOAD;
                default:    dec_st = lpDROP;
            endcase

            if (dec_st == lpSFD) begin
                crc_d = lpCRC_INIT;
                len_d = 11'd0;
            end else if (in_body(dec_st)) begin
                crc_d = crc_next;
                len_d = (len_q == lpLEN_SAT) ? len_q : len_q + 11'd1;
            end

            state_d = dec_st;
            if (irx_er && in_frame(dec_st)) begin
                er_d    = 1'b1;
                state_d = lpDROP;
            end
        end else if (in_frame(state_q)) begin
            if (state_q == lpPAYLOAD && crc_q == lpCRC_RESIDUE &&
                len_q >= MIN_LEN && len_q <= MAX_LEN) begin
                ok_d = 1'b1;
            end else begin
                er_d = 1'b1;
            end
        end

        odv_d      = in_frame(dec_st);
        good_cnt_d = (ok_d && !(&good_cnt_q)) ? good_cnt_q + pCNT_WIDTH'(1) : good_cnt_q;
        bad_cnt_d  = (er_d && !(&bad_cnt_q))  ? bad_cnt_q + pCNT_WIDTH'(1)  : bad_cnt_q;
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            // Rest in DROP so a frame still in flight at release is discarded.
            state_q    <= lpDROP;
            fst_q      <= lpIDLE;
            fcnt_q     <= 3'd0;
            crc_q      <= 32'd0;
            len_q      <= 11'd0;
            odv_q      <= 1'b0;
            rxd_q      <= '0;
            er_q       <= 1'b0;
            ok_q       <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            fst_q      <= dec_st;
            fcnt_q     <= fcnt_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            odv_q      <= odv_d;
            rxd_q      <= irx_d;
            er_q       <= er_d;
            ok_q       <= ok_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign odv          = odv_q;
    assign orx_d        = rxd_q;
    assign orx_er       = er_q;
    assign ook          = ok_q;
    assign oframe_state = fst_q;
    assign ogood_cnt    = good_cnt_q;
    assign obad_cnt     = bad_cnt_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed and randomized frames checked per cycle against a position-based frame model.
module tb_rx_frame_parser;
    import rx_frame_parser_pkg::*;

    logic        iclk, irst, idv, irx_er;
    logic [7:0]  irx_d;
    logic        odv, orx_er, ook;
    logic [7:0]  orx_d;
    logic [2:0]  oframe_state;
    logic [15:0] ogood_cnt, obad_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Expectation for the outputs produced by the most recently applied input.
    logic       p_en = 1'b0;
    logic       p_dv, p_rst, p_ok, p_bad;
    logic [7:0] p_d;
    logic [2:0] p_st;
    int         p_gc, p_bc;
    int         m_gc = 0;
    int         m_bc = 0;

    logic [7:0] fr[$];

    rx_frame_parser dut (
        .iclk         (iclk),
        .irst         (irst),
        .idv          (idv),
        .irx_d        (irx_d),
        .irx_er       (irx_er),
        .odv          (odv),
        .orx_d        (orx_d),
        .orx_er       (orx_er),
        .oframe_state (oframe_state),
        .ook          (ook),
        .ogood_cnt    (ogood_cnt),
        .obad_cnt     (obad_cnt)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit-serial CRC-32 of the first n bytes, returned as the FCS value.
    function automatic logic [31:0] fcs_of(input logic [7:0] q[$], input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        logic        fb;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic logic [2:0] field_of(input int k);
        if (k < 6)  return lpDA;
        if (k < 12) return lpSA;
        if (k < 14) return lpTYPE;
        return lpPAYLOAD;
    endfunction

    task automatic cyc(input logic dv, input logic [7:0] d, input logic er, input logic rst,
                       input logic e_dv, input logic [7:0] e_d, input logic [2:0] e_st,
                       input logic e_ok, input logic e_bad);
        @(posedge iclk);
        #1;
        if (p_en) begin
            chk("odv", 32'(odv), 32'(p_dv));
            if (p_dv || p_rst) chk("orx_d", 32'(orx_d), 32'(p_d));
            chk("oframe_state", 32'(oframe_state), 32'(p_st));
            chk("ook", 32'(ook), 32'(p_ok));
            chk("orx_er", 32'(orx_er), 32'(p_bad));
            chk("ogood_cnt", 32'(ogood_cnt), 32'(p_gc));
            chk("obad_cnt", 32'(obad_cnt), 32'(p_bc));
        end
        idv = dv; irx_d = d; irx_er = er; irst = rst;
        p_en = 1'b1; p_dv = e_dv; p_d = e_d; p_st = e_st;
        p_ok = e_ok; p_bad = e_bad; p_rst = rst;
        p_gc = m_gc; p_bc = m_bc;
    endtask

    // nbytes counts DA through FCS; err_k / rst_k index bytes after the SFD (-1 = none).
    task automatic send_frame(input int plen, input int nbytes, input logic corrupt,
                              input int err_k, input int rst_k);
        logic [31:0] fcs;
        logic        dropped = 1'b0;
        logic        good;
        fr.delete();
        for (int i = 0; i < nbytes - 4; i++) fr.push_back(8'($urandom));
        if (nbytes >= 4) begin
            fcs = fcs_of(fr, nbytes - 4);
            for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
            if (corrupt) fr[nbytes-4][0] = ~fr[nbytes-4][0];
        end else begin
            for (int i = 0; i < nbytes; i++) fr.push_back(8'($urandom));
        end

        for (int i = 0; i < plen; i++) cyc(1, 8'h55, 0, 0, 0, 8'h55, lpPREAMBLE, 0, 0);
        cyc(1, 8'hD5, 0, 0, 1, 8'hD5, lpSFD, 0, 0);
        for (int k = 0; k < nbytes; k++) begin
            if (dropped) begin
                cyc(1, fr[k], 0, 0, 0, fr[k], lpDROP, 0, 0);
            end else if (k == rst_k) begin
                m_gc = 0; m_bc = 0;
                cyc(1, fr[k], 0, 1, 0, 8'h00, lpIDLE, 0, 0);
                dropped = 1'b1;
            end else if (k == err_k) begin
                m_bc++;
                cyc(1, fr[k], 1, 0, 1, fr[k], field_of(k), 0, 1);
                dropped = 1'b1;
            end else begin
                cyc(1, fr[k], 0, 0, 1, fr[k], field_of(k), 0, 0);
            end
        end

        if (dropped) begin
            cyc(0, 8'h00, 0, 0, 0, 8'h00, lpIDLE, 0, 0);
        end else begin
            good = (nbytes >= 15) && (nbytes >= 64) && (nbytes <= 1518) &&
                   (fcs_of(fr, nbytes - 4) == {fr[nbytes-1], fr[nbytes-2], fr[nbytes-3], fr[nbytes-4]});
            if (good) m_gc++; else m_bc++;
            cyc(0, 8'h00, 0, 0, 0, 8'h00, lpIDLE, good, !good);
        end
    endtask

    initial begin
        idv = 0; irx_d = 0; irx_er = 0; irst = 1;
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 1, 0, 8'h00, lpIDLE, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 8'h00, lpIDLE, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 8'h00, lpIDLE, 0, 0);

        send_frame(7, 64, 0, -1, -1);
        send_frame(7, 64, 1, -1, -1);
        send_frame(7, 40, 0, -1, -1);
        send_frame(7, 1519, 0, -1, -1);
        send_frame(7, 64, 0, 19, -1);
        send_frame(7, 64, 0, -1, 43);
        send_frame(7, 64, 0, -1, -1);
        send_frame(7, 64, 0, -1, -1);
        send_frame(7, 1518, 0, -1, -1);
        send_frame(3, 13, 0, -1, -1);
        send_frame(2, 0, 0, -1, -1);
        send_frame(1, 20, 0, -1, -1);

        // Broken preamble: dropped without verdict, irx_er ignored outside a frame.
        cyc(1, 8'h55, 1, 0, 0, 8'h55, lpPREAMBLE, 0, 0);
        cyc(1, 8'h3C, 0, 0, 0, 8'h3C, lpDROP, 0, 0);
        cyc(1, 8'hD5, 1, 0, 0, 8'hD5, lpDROP, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 8'h00, lpIDLE, 0, 0);
        cyc(1, 8'hD5, 0, 0, 0, 8'hD5, lpDROP, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 8'h00, lpIDLE, 0, 0);

        for (int f = 0; f < 10; f++) begin
            send_frame($urandom_range(1, 8), $urandom_range(40, 120), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, 39) : -1, -1);
        end

        cyc(0, 8'h00, 0, 0, 0, 8'h00, lpIDLE, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 8'h00, lpIDLE, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
